// File: rtl/bitnet_mem_pkg.sv
// Shared types for the BRAM-wrapper clients: fetcher state encoding and the
// stream beat carried from the wrapper to the compute datapath.
package bitnet_mem_pkg;

   localparam int VEC_WIDTH     = 2048;
   localparam int VEC_ADDR_SIZE = 10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } fetch_state_t;

   // Fields are sized for the largest wrapper; narrower builds zero-extend.
   typedef struct packed {
      logic [VEC_WIDTH-1:0]     data;
      logic [VEC_ADDR_SIZE-1:0] addr;
      logic                     last;
   } vec_beat_t;

endpackage

// File: rtl/vector_skid_buffer.sv
// Two-entry valid/ready FIFO of vec_beat_t; lets the fetcher keep one read
// in flight while the consumer stalls on the previous beat.
module vector_skid_buffer
   import bitnet_mem_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       i_valid,
   input  vec_beat_t  i_beat,
   output logic       o_in_ready,
   output logic       o_valid,
   output vec_beat_t  o_beat,
   input  logic       i_ready,
   output logic [1:0] o_level
);

   vec_beat_t  r_head;
   vec_beat_t  r_tail;
   logic [1:0] r_level;
   logic       w_push;
   logic       w_pop;

   assign w_push = i_valid && (r_level != 2'd2);
   assign w_pop  = (r_level != 2'd0) && i_ready;

   // Head always holds the oldest beat, so the output payload only moves on a pop.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_level <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_level == 2'd0) begin
                  r_head <= i_beat;
               end else begin
                  r_tail <= i_beat;
               end
               r_level <= r_level + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_level <= r_level - 2'd1;
            end
            2'b11: begin
               if (r_level == 2'd1) begin
                  r_head <= i_beat;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_beat;
               end
            end
            default: begin
               r_level <= r_level;
            end
         endcase
      end
   end

   assign o_in_ready = (r_level != 2'd2);
   assign o_valid    = (r_level != 2'd0);
   assign o_beat     = r_head;
   assign o_level    = r_level;

endmodule

// File: rtl/vector_fetcher.sv
// Sequences count_in reads from base_addr_in through the BRAM wrapper and streams them out.
// Build option VECTOR_FETCHER_PREFETCH_EN: two-entry output buffer so read i+1 overlaps a stalled beat i.
module vector_fetcher
   import bitnet_mem_pkg::*;
#(
   parameter int ADDRS = 1024,
   parameter int WIDTH = 2048,
   localparam int ADDR_SIZE = $clog2(ADDRS)
)(
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic [ADDR_SIZE-1:0] base_addr_in,
   input  logic [ADDR_SIZE:0]   count_in,
   output logic                 busy_out,
   output logic                 done_out,
   output logic [ADDR_SIZE-1:0] mem_addr_out,
   output logic                 mem_read_enable_out,
   input  logic [WIDTH-1:0]     mem_data_in,
   input  logic                 mem_finished_in,
   output logic [WIDTH-1:0]     vec_data_out,
   output logic [ADDR_SIZE-1:0] vec_addr_out,
   output logic                 vec_last_out,
   output logic                 vec_valid_out,
   input  logic                 vec_ready_in
);

   fetch_state_t         r_state;
   logic [ADDR_SIZE-1:0] r_addr;
   logic [ADDR_SIZE:0]   r_count;
   logic [ADDR_SIZE:0]   r_issued;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_rd_en;
   logic                 w_push;
   logic                 w_last;
   logic                 w_out_valid;
   logic                 w_free;
   logic                 w_free_after_cap;
   logic                 w_drained;
   logic [ADDR_SIZE-1:0] w_next_addr;

   // Completions outside WAIT (stale pulses, foreign writes) never reach the buffer.
   assign w_push      = (r_state == WAIT) && mem_finished_in;
   assign w_last      = (r_issued == r_count);
   assign w_next_addr = (r_addr == ADDR_SIZE'(ADDRS - 1)) ? {ADDR_SIZE{1'b0}} : r_addr + ADDR_SIZE'(1);

`ifdef VECTOR_FETCHER_PREFETCH_EN
   vec_beat_t  w_in_beat;
   vec_beat_t  w_out_beat;
   logic [1:0] w_level;
   logic       w_in_ready;

   assign w_in_beat = '{data: VEC_WIDTH'(mem_data_in), addr: VEC_ADDR_SIZE'(r_addr), last: w_last};

   vector_skid_buffer u_skid (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .i_valid    (w_push),
      .i_beat     (w_in_beat),
      .o_in_ready (w_in_ready),
      .o_valid    (w_out_valid),
      .o_beat     (w_out_beat),
      .i_ready    (vec_ready_in),
      .o_level    (w_level)
   );

   assign w_free           = w_in_ready || vec_ready_in;
   assign w_free_after_cap = (w_level == 2'd0) || ((w_level == 2'd1) && vec_ready_in);
   assign w_drained        = w_free_after_cap;
   assign vec_valid_out    = w_out_valid;
   assign vec_data_out     = w_out_beat.data[WIDTH-1:0];
   assign vec_addr_out     = w_out_beat.addr[ADDR_SIZE-1:0];
   assign vec_last_out     = w_out_beat.last;
`else
   logic                 r_vld;
   logic [WIDTH-1:0]     r_vdata;
   logic [ADDR_SIZE-1:0] r_vaddr;
   logic                 r_vlast;

   // Single output register; a capture only happens while it is empty.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_vld   <= 1'b0;
         r_vdata <= {WIDTH{1'b0}};
         r_vaddr <= {ADDR_SIZE{1'b0}};
         r_vlast <= 1'b0;
      end else if (w_push) begin
         r_vld   <= 1'b1;
         r_vdata <= mem_data_in;
         r_vaddr <= r_addr;
         r_vlast <= w_last;
      end else if (r_vld && vec_ready_in) begin
         r_vld <= 1'b0;
      end else begin
         r_vld <= r_vld;
      end
   end

   assign w_out_valid      = r_vld;
   assign w_free           = !r_vld || vec_ready_in;
   assign w_free_after_cap = 1'b0;
   assign w_drained        = w_free;
   assign vec_valid_out    = r_vld;
   assign vec_data_out     = r_vdata;
   assign vec_addr_out     = r_vaddr;
   assign vec_last_out     = r_vlast;
`endif

   // Run sequencer; read enable and done are registered one-cycle pulses.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state  <= IDLE;
         r_addr   <= {ADDR_SIZE{1'b0}};
         r_count  <= {(ADDR_SIZE+1){1'b0}};
         r_issued <= {(ADDR_SIZE+1){1'b0}};
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_rd_en  <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_in) begin
                  r_addr  <= base_addr_in;
                  r_count <= count_in;
                  r_busy  <= 1'b1;
                  if (count_in == {(ADDR_SIZE+1){1'b0}}) begin
                     r_state <= DONE;
                  end else begin
                     r_state  <= ISSUE;
                     r_rd_en  <= 1'b1;
                     r_issued <= (ADDR_SIZE+1)'(1);
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            ISSUE: begin
               r_state <= WAIT;
            end
            WAIT: begin
               if (mem_finished_in) begin
                  r_addr <= w_next_addr;
                  if (w_last) begin
                     r_state <= DRAIN;
                  end else if (w_free_after_cap) begin
                     r_state  <= ISSUE;
                     r_rd_en  <= 1'b1;
                     r_issued <= r_issued + (ADDR_SIZE+1)'(1);
                  end else begin
                     r_state <= HOLD;
                  end
               end else begin
                  r_state <= WAIT;
               end
            end
            HOLD: begin
               if (w_free) begin
                  r_state  <= ISSUE;
                  r_rd_en  <= 1'b1;
                  r_issued <= r_issued + (ADDR_SIZE+1)'(1);
               end else begin
                  r_state <= HOLD;
               end
            end
            DRAIN: begin
               if (w_drained) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= DRAIN;
               end
            end
            DONE: begin
               // A zero-length run arrives here without the pulse and emits it one cycle later.
               if (r_done) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy_out            = r_busy;
   assign done_out            = r_done;
   assign mem_addr_out        = r_addr;
   assign mem_read_enable_out = r_rd_en;

endmodule
